// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared writer descriptor type and register constants for fwd_scoreboard
package fwd_pkg;

   // Descriptor field widths; the scoreboard's DW/AW parameters default to these.
   localparam int FWD_DW = 32;
   localparam int FWD_AW = 5;

   localparam int REG_ZERO = 0;
   localparam int REG_LINK = 31;

   typedef struct packed {
      logic              valid;
      logic              we;
      logic [FWD_AW-1:0] dst;
      logic              is_load;
      logic              is_jal;
      logic [FWD_DW-1:0] link;
   } fwd_desc_t;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - one source channel's youngest-writer search across the tracked stages
module fwd_select
   import fwd_pkg::*;
#(
   parameter int DW       = FWD_DW,
   parameter int AW       = FWD_AW,
   parameter int DEPTH    = 3,
   parameter int LOAD_LAT = 1
) (
   input  fwd_desc_t [DEPTH-1:0] desc_i,
   input  logic [DEPTH*DW-1:0]   stg_data_i,
   input  logic [AW-1:0]         src_addr_i,
   input  logic [DW-1:0]         rf_data_i,
   output logic [DW-1:0]         fwd_data_o,
   output logic                  hit_o,
   output logic                  hazard_o
);

   // Scan oldest to youngest so the lowest-index match overwrites older ones.
   always_comb begin
      fwd_data_o = rf_data_i;
      hit_o      = 1'b0;
      hazard_o   = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (desc_i[i].valid && desc_i[i].we && (desc_i[i].dst == src_addr_i) &&
             (src_addr_i != AW'(REG_ZERO))) begin
            hit_o      = 1'b1;
            hazard_o   = desc_i[i].is_load && (i < LOAD_LAT);
            fwd_data_o = desc_i[i].is_jal ? desc_i[i].link : stg_data_i[i*DW +: DW];
         end
      end
   end

endmodule

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - ID/EX forwarding and load-use hazard block; FWD_SCOREBOARD_STATS_EN adds stall/forward counters
module fwd_scoreboard
   import fwd_pkg::*;
#(
   parameter int DW       = FWD_DW,
   parameter int AW       = FWD_AW,
   parameter int NSRC     = 2,
   parameter int DEPTH    = 3,
   parameter int LOAD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [NSRC*AW-1:0]   id_src_addr,
   input  logic [NSRC*DW-1:0]   id_src_data,
   input  logic                 id_we,
   input  logic [AW-1:0]        id_dst,
   input  logic                 id_is_load,
   input  logic                 id_is_jal,
   input  logic [DW-1:0]        id_link,
   input  logic                 flush,
   input  logic [DEPTH*DW-1:0]  stg_data,
   output logic                 stall,
   output logic                 ex_valid,
   output logic [NSRC*DW-1:0]   ex_opnd,
`ifdef FWD_SCOREBOARD_STATS_EN
   output logic [31:0]          stat_stall,
   output logic [31:0]          stat_fwd,
`endif
   output logic                 wb_we,
   output logic [AW-1:0]        wb_addr,
   output logic [DW-1:0]        wb_data
);

   fwd_desc_t [DEPTH-1:0] desc_q, desc_d;
   fwd_desc_t             id_desc;
   logic                  ex_valid_q;
   logic [NSRC*DW-1:0]    ex_opnd_q, ex_opnd_d;
   logic [NSRC*DW-1:0]    fwd_data;
   logic [NSRC-1:0]       hit, hazard;
   logic                  issue;

   for (genvar k = 0; k < NSRC; k++) begin : g_ch
      fwd_select #(
         .DW       (DW),
         .AW       (AW),
         .DEPTH    (DEPTH),
         .LOAD_LAT (LOAD_LAT)
      ) u_sel (
         .desc_i     (desc_q),
         .stg_data_i (stg_data),
         .src_addr_i (id_src_addr[k*AW +: AW]),
         .rf_data_i  (id_src_data[k*DW +: DW]),
         .fwd_data_o (fwd_data[k*DW +: DW]),
         .hit_o      (hit[k]),
         .hazard_o   (hazard[k])
      );
   end

   // Flush overrides a pending load-use stall; the stall clears as the load ages.
   assign stall = id_valid & ~flush & (|(hit & hazard));
   assign issue = id_valid & ~stall & ~flush;

   always_comb begin
      id_desc         = '0;
      id_desc.valid   = 1'b1;
      id_desc.we      = id_we;
      id_desc.dst     = id_dst;
      id_desc.is_load = id_is_load;
      id_desc.is_jal  = id_is_jal;
      id_desc.link    = id_link;
      desc_d[0] = issue ? id_desc : '0;
      for (int i = 1; i < DEPTH; i++) begin
         desc_d[i] = desc_q[i-1];
      end
      ex_opnd_d = issue ? fwd_data : ex_opnd_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         desc_q     <= '0;
         ex_valid_q <= 1'b0;
         ex_opnd_q  <= '0;
      end else begin
         desc_q     <= desc_d;
         ex_valid_q <= issue;
         ex_opnd_q  <= ex_opnd_d;
      end
   end

   assign ex_valid = ex_valid_q;
   assign ex_opnd  = ex_opnd_q;

   assign wb_we   = desc_q[DEPTH-1].valid & desc_q[DEPTH-1].we & (desc_q[DEPTH-1].dst != AW'(REG_ZERO));
   assign wb_addr = desc_q[DEPTH-1].dst;
   assign wb_data = desc_q[DEPTH-1].is_jal ? desc_q[DEPTH-1].link : stg_data[(DEPTH-1)*DW +: DW];

`ifdef FWD_SCOREBOARD_STATS_EN
   logic [31:0] stat_stall_q, stat_fwd_q;
   logic [32:0] fwd_sum;

   always_comb begin
      fwd_sum = {1'b0, stat_fwd_q};
      if (issue) begin
         for (int k = 0; k < NSRC; k++) begin
            fwd_sum = fwd_sum + 33'(hit[k]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_stall_q <= '0;
         stat_fwd_q   <= '0;
      end else begin
         if (stall && (stat_stall_q != '1)) begin
            stat_stall_q <= stat_stall_q + 32'd1;
         end
         stat_fwd_q <= fwd_sum[32] ? '1 : fwd_sum[31:0];
      end
   end

   assign stat_stall = stat_stall_q;
   assign stat_fwd   = stat_fwd_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - directed self-checking bench for fwd_scoreboard
module tb_fwd_scoreboard;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NSRC  = 2;
   localparam int DEPTH = 3;

   logic                clk = 1'b0;
   logic                rst;
   logic                id_valid;
   logic [NSRC*AW-1:0]  id_src_addr;
   logic [NSRC*DW-1:0]  id_src_data;
   logic                id_we;
   logic [AW-1:0]       id_dst;
   logic                id_is_load;
   logic                id_is_jal;
   logic [DW-1:0]       id_link;
   logic                flush;
   logic [DEPTH*DW-1:0] stg_data;
   logic                stall;
   logic                ex_valid;
   logic [NSRC*DW-1:0]  ex_opnd;
   logic                wb_we;
   logic [AW-1:0]       wb_addr;
   logic [DW-1:0]       wb_data;
`ifdef FWD_SCOREBOARD_STATS_EN
   logic [31:0]         stat_stall;
   logic [31:0]         stat_fwd;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fwd_scoreboard dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_src_addr (id_src_addr),
      .id_src_data (id_src_data),
      .id_we       (id_we),
      .id_dst      (id_dst),
      .id_is_load  (id_is_load),
      .id_is_jal   (id_is_jal),
      .id_link     (id_link),
      .flush       (flush),
      .stg_data    (stg_data),
      .stall       (stall),
      .ex_valid    (ex_valid),
      .ex_opnd     (ex_opnd),
`ifdef FWD_SCOREBOARD_STATS_EN
      .stat_stall  (stat_stall),
      .stat_fwd    (stat_fwd),
`endif
      .wb_we       (wb_we),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid    = 1'b0;
      id_we       = 1'b0;
      id_dst      = '0;
      id_is_load  = 1'b0;
      id_is_jal   = 1'b0;
      id_link     = '0;
      id_src_addr = '0;
      id_src_data = '0;
      flush       = 1'b0;
   endtask

   task automatic instr(input logic we, input logic [AW-1:0] dst, input logic ld, input logic jal,
                        input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] link);
      id_valid    = 1'b1;
      id_we       = we;
      id_dst      = dst;
      id_is_load  = ld;
      id_is_jal   = jal;
      id_link     = link;
      id_src_addr = {s1, s0};
      id_src_data = {d1, d0};
      flush       = 1'b0;
   endtask

   task automatic set_stg(input logic [DW-1:0] s0, input logic [DW-1:0] s1, input logic [DW-1:0] s2);
      stg_data = {s2, s1, s0};
   endtask

   initial begin
      idle();
      set_stg(32'h0, 32'h0, 32'h0);
      rst = 1'b1;
      tick();
      tick();
      check("rst_stall",    64'(stall),    64'd0);
      check("rst_ex_valid", 64'(ex_valid), 64'd0);
      check("rst_ex_opnd",  64'(ex_opnd),  64'd0);
      check("rst_wb_we",    64'(wb_we),    64'd0);
      check("rst_wb_addr",  64'(wb_addr),  64'd0);
      check("rst_wb_data",  64'(wb_data),  64'd0);
      rst = 1'b0;

      // ALU back-to-back: add r3 then a reader of r3
      instr(1'b1, 5'd3, 1'b0, 1'b0, 5'd1, 5'd2, 32'hA, 32'hB, 32'h0);
      #1 check("alu_i1_stall", 64'(stall), 64'd0);
      tick();
      check("alu_i1_ex_valid", 64'(ex_valid), 64'd1);
      check("alu_i1_opnd", 64'(ex_opnd), 64'h0000000B_0000000A);
      set_stg(32'h11, 32'h0, 32'h0);
      instr(1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd4, 32'h0, 32'h44, 32'h0);
      #1 check("alu_i2_stall", 64'(stall), 64'd0);
      tick();
      check("alu_fwd_opnd", 64'(ex_opnd), 64'h00000044_00000011);
      check("alu_i2_ex_valid", 64'(ex_valid), 64'd1);
      idle();
      set_stg(32'h0, 32'h0, 32'h33);
      tick();
      check("alu_wb_we",   64'(wb_we),   64'd1);
      check("alu_wb_addr", 64'(wb_addr), 64'd3);
      check("alu_wb_data", 64'(wb_data), 64'h33);
      check("idle_ex_valid", 64'(ex_valid), 64'd0);
      check("idle_opnd_held", 64'(ex_opnd), 64'h00000044_00000011);
      tick();
      tick();

      // Load-use: lw r5 then reader of r5 stalls one cycle
      set_stg(32'h0, 32'h0, 32'h0);
      instr(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      tick();
      instr(1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 32'h99, 32'h0, 32'h0);
      #1 check("lu_stall", 64'(stall), 64'd1);
      tick();
      check("lu_bubble", 64'(ex_valid), 64'd0);
      set_stg(32'h0, 32'hDEAD, 32'h0);
      #1 check("lu_release", 64'(stall), 64'd0);
      tick();
      check("lu_fwd_opnd", 64'(ex_opnd[DW-1:0]), 64'hDEAD);
      check("lu_ex_valid", 64'(ex_valid), 64'd1);
`ifdef FWD_SCOREBOARD_STATS_EN
      check("stat_stall", 64'(stat_stall), 64'd1);
      check("stat_fwd",   64'(stat_fwd),   64'd2);
`endif
      idle();
      tick();
      tick();
      tick();

      // Priority: r7 at stages 2 and 0, r0 writer at stage 1
      set_stg(32'h0, 32'h0, 32'h0);
      instr(1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      tick();
      instr(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      tick();
      instr(1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      tick();
      instr(1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd0, 32'h77, 32'h0, 32'h0);
      set_stg(32'h1, 32'h5, 32'h2);
      #1 check("prio_stall", 64'(stall), 64'd0);
      check("prio_wb_we",   64'(wb_we),   64'd1);
      check("prio_wb_addr", 64'(wb_addr), 64'd7);
      check("prio_wb_data", 64'(wb_data), 64'h2);
      tick();
      check("prio_youngest", 64'(ex_opnd[DW-1:0]),  64'h1);
      check("prio_r0",       64'(ex_opnd[2*DW-1:DW]), 64'h0);
      idle();
      #1 check("wb_r0_we", 64'(wb_we), 64'd0);
      tick();
      tick();
      tick();

      // JAL: link value forwarded and written back despite garbage stage data
      set_stg(32'hBAD0, 32'hBAD1, 32'hBAD2);
      instr(1'b1, 5'd31, 1'b0, 1'b1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0040_0008);
      tick();
      instr(1'b0, 5'd0, 1'b0, 1'b0, 5'd31, 5'd0, 32'h0, 32'h0, 32'h0);
      #1 check("jal_stall", 64'(stall), 64'd0);
      tick();
      check("jal_fwd", 64'(ex_opnd[DW-1:0]), 64'h0040_0008);
      idle();
      tick();
      check("jal_wb_we",   64'(wb_we),   64'd1);
      check("jal_wb_addr", 64'(wb_addr), 64'd31);
      check("jal_wb_data", 64'(wb_data), 64'h0040_0008);
      tick();
      tick();

      // Flush during a pending load-use stall
      set_stg(32'h0, 32'h0, 32'h0);
      instr(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      tick();
      instr(1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd0, 32'h0, 32'h0, 32'h0);
      #1 check("fl_pre_stall", 64'(stall), 64'd1);
      flush = 1'b1;
      #1 check("fl_stall", 64'(stall), 64'd0);
      tick();
      check("fl_ex_valid", 64'(ex_valid), 64'd0);
      idle();
      tick();
      tick();
      tick();

      // Reset asserted mid-stall
      instr(1'b1, 5'd10, 1'b1, 1'b0, 5'd1, 5'd0, 32'h1234, 32'h0, 32'h0);
      tick();
      check("rs_ld_opnd", 64'(ex_opnd), 64'h1234);
      instr(1'b0, 5'd0, 1'b0, 1'b0, 5'd10, 5'd0, 32'h0, 32'h0, 32'h0);
      #1 check("rs_pre_stall", 64'(stall), 64'd1);
      rst = 1'b1;
      tick();
      check("rs_stall",    64'(stall),    64'd0);
      check("rs_ex_valid", 64'(ex_valid), 64'd0);
      check("rs_ex_opnd",  64'(ex_opnd),  64'd0);
      check("rs_wb_we",    64'(wb_we),    64'd0);
      check("rs_wb_addr",  64'(wb_addr),  64'd0);
      check("rs_wb_data",  64'(wb_data),  64'd0);
      rst = 1'b0;
      idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
